// File: rtl/led_pattern_seq_if.sv
// ---------------------------------------------------------------------------
// led_pattern_seq_if
//
// Control and display bundle for the running-light sequencer.
//
// The master side is the board front end: mode switches, auto switch,
// push-button start and abort. The slave side is the sequencer, which
// drives the lamp bank and its status flags.
//
//   S       master->slave  2  mode select, sampled only when start is accepted
//   auto    master->slave  1  1 = play modes S..3 back to back
//   start   master->slave  1  level or pulse, accepted only while idle
//   stop    master->slave  1  synchronous abort
//   Y       slave->master  N  lamp drive, 1 = lit, Y[N-1] is the leftmost lamp
//   busy    slave->master  1  high while a sequence is playing
//   done    slave->master  1  one-cycle pulse on normal completion
//   mode_o  slave->master  2  mode currently playing
// ---------------------------------------------------------------------------
interface led_pattern_seq_if #(
    parameter int N = 8
);
    logic [1:0]   S;
    logic         auto;
    logic         start;
    logic         stop;
    logic [N-1:0] Y;
    logic         busy;
    logic         done;
    logic [1:0]   mode_o;

    modport master (
        output S, auto, start, stop,
        input  Y, busy, done, mode_o
    );

    modport slave (
        input  S, auto, start, stop,
        output Y, busy, done, mode_o
    );
endinterface

// File: rtl/led_pattern_seq.sv
// ---------------------------------------------------------------------------
// led_pattern_seq
//
// Parametrised running-light sequencer for a bank of N lamps. It plays one
// of four display modes, or modes S..3 back to back when auto is set. Each
// mode is played REPEAT times and every frame is held for DIV clock cycles.
//
// Modes (H = N/2, "top k" = leftmost k lamps):
//   0  fill from the left, then empty from the left          (2N frames)
//   1  both halves fill from the outer edges, then empty     (N frames)
//   2  walk one lamp showing PATTERN bit by bit, then
//      show the whole PATTERN                                (N+1 frames)
//   3  single lamp bounces left-to-right-to-left             (2N-2 frames)
//
// Parameters
//   N        lamp count, even, 4..32
//   DIV      clock cycles per frame, >= 1
//   REPEAT   passes per mode, 1..15
//   PATTERN  mode-2 sequence, MSB = leftmost lamp
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave side of led_pattern_seq_if (S, auto, start, stop in;
//            Y, busy, done, mode_o out)
// ---------------------------------------------------------------------------
module led_pattern_seq #(
    parameter int           N       = 8,
    parameter int           DIV     = 50_000_000,
    parameter int           REPEAT  = 2,
    parameter logic [N-1:0] PATTERN = {{(N/2){1'b1}}, {(N/2){1'b0}}}
) (
    input  logic             clk,
    input  logic             reset_n,
    led_pattern_seq_if.slave bus
);

    localparam int H  = N / 2;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    // Frame index must reach 2N-1 (last frame of mode 0).
    localparam int FW = $clog2(2 * N);

    localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
    localparam logic [3:0]    P_LAST = 4'(REPEAT - 1);

    localparam logic [N-1:0] ONES  = '1;
    localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [H-1:0] HONES = '1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q;
    logic [1:0]    mode_q;
    logic          auto_q;
    logic [FW-1:0] f_q;
    logic [3:0]    p_q;
    logic [DW-1:0] d_q;
    logic [N-1:0]  y_q;
    logic          busy_q;
    logic          done_q;

    logic [FW-1:0] f_last;

    // Index of the final frame of a mode.
    function automatic logic [FW-1:0] last_frame(input logic [1:0] mode);
        logic [FW-1:0] r;
        case (mode)
            2'd0:    r = FW'(2 * N - 1);
            2'd1:    r = FW'(N - 1);
            2'd2:    r = FW'(N);
            default: r = FW'(2 * N - 3);
        endcase
        return r;
    endfunction

    // Lamp image for frame fr of a mode. Built from shifts of all-ones or
    // one-hot constants so no variable bit-selects are needed.
    function automatic logic [N-1:0] frame_of(input logic [1:0]    mode,
                                              input logic [FW-1:0] fr);
        int           f;
        logic [N-1:0] v;
        logic [H-1:0] lh;
        logic [H-1:0] rh;
        f  = int'(fr);
        v  = '0;
        lh = '0;
        rh = '0;
        case (mode)
            2'd0: begin
                // Filling: top f+1 lit. Emptying: ones shifted right so the
                // top f-N+1 lamps are dark.
                if (f < N) v = ONES << (N - 1 - f);
                else       v = ONES >> (f - N + 1);
            end
            2'd1: begin
                // Left half grows from its MSB, right half from its LSB;
                // on the way out they clear in the same order.
                if (f < H) begin
                    lh = ~(HONES >> (f + 1));
                    rh = ~(HONES << (f + 1));
                end else begin
                    lh = HONES >> (f - H + 1);
                    rh = HONES << (f - H + 1);
                end
                v = {lh, rh};
            end
            2'd2: begin
                if (f < N) v = PATTERN & (ONE << (N - 1 - f));
                else       v = PATTERN;
            end
            default: begin
                // Outbound sweep covers N-1..0, return sweep covers 1..N-2.
                if (f < N) v = ONE << (N - 1 - f);
                else       v = ONE << (f - N + 1);
            end
        endcase
        return v;
    endfunction

    always_comb begin
        f_last = last_frame(mode_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            auto_q  <= 1'b0;
            f_q     <= '0;
            p_q     <= 4'd0;
            d_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                // stop wins over start; Y keeps its final value while idle.
                if (bus.start && !bus.stop) begin
                    state_q <= ST_RUN;
                    mode_q  <= bus.S;
                    auto_q  <= bus.auto;
                    f_q     <= '0;
                    p_q     <= 4'd0;
                    d_q     <= '0;
                    y_q     <= frame_of(bus.S, '0);
                    busy_q  <= 1'b1;
                end
            end else begin
                if (bus.stop) begin
                    state_q <= ST_IDLE;
                    f_q     <= '0;
                    p_q     <= 4'd0;
                    d_q     <= '0;
                    y_q     <= '0;
                    busy_q  <= 1'b0;
                end else if (d_q != D_LAST) begin
                    d_q <= d_q + DW'(1);
                end else begin
                    // Frame boundary: next frame, next pass, next mode, or end.
                    d_q <= '0;
                    if (f_q != f_last) begin
                        f_q <= f_q + FW'(1);
                        y_q <= frame_of(mode_q, f_q + FW'(1));
                    end else if (p_q != P_LAST) begin
                        f_q <= '0;
                        p_q <= p_q + 4'd1;
                        y_q <= frame_of(mode_q, '0);
                    end else if (auto_q && (mode_q != 2'd3)) begin
                        mode_q <= mode_q + 2'd1;
                        f_q    <= '0;
                        p_q    <= 4'd0;
                        y_q    <= frame_of(mode_q + 2'd1, '0);
                    end else begin
                        // Mode 3 ends on a lit lamp, so force the resting
                        // image rather than keeping the last frame.
                        state_q <= ST_IDLE;
                        f_q     <= '0;
                        p_q     <= 4'd0;
                        y_q     <= (mode_q == 2'd2) ? PATTERN : '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.Y      = y_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.mode_o = mode_q;

endmodule
